// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Length header is two bytes, most significant first.
    localparam int HDR_BYTES = 2;

    // A payload length must fit in imem and be a whole number of 32-bit words.
    function automatic logic len_legal(input logic [15:0] len, input int unsigned max_bytes);
        return ({16'd0, len} <= max_bytes) && (len[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem byte-write port of the boot loader.
interface imem_loader_if #(
    parameter int ADDR_BUS_WIDTH = 16
);
    logic                      in_valid;
    logic [7:0]                in_data;
    logic                      in_ready;
    logic                      mem_we;
    logic [ADDR_BUS_WIDTH-1:0] mem_addr;
    logic [7:0]                mem_wdata;

    // Host link / imem side: supplies bytes, observes writes.
    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    // Loader side: consumes bytes, drives the imem write port.
    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader_byte_timeout.sv
// Inter-byte watchdog: reloads on clear, counts down while enabled,
// flags expiry on the CYCLES-th consecutive enabled cycle.
module byte_timeout #(
    parameter int unsigned CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload on clear, otherwise step down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = RELOAD;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && !clear_i && (cnt_q == '0);

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses a length/payload/checksum frame from a byte stream,
// writes the payload to imem from address 0 and stalls the core meanwhile.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_BUS_WIDTH = 16,
    parameter int unsigned MEM_BYTES      = 128,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    imem_loader_if.slave   bus,
    output logic           cpu_hold,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [1:0]     err_code
);
    state_t                    state_q, state_d;
    logic [15:0]               len_q, len_d;
    logic [ADDR_BUS_WIDTH-1:0] idx_q, idx_d;
    logic [7:0]                sum_q, sum_d;
    logic [1:0]                code_q, code_d;
    logic                      we_q, we_d;
    logic [ADDR_BUS_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                wdata_q, wdata_d;

    logic                      active;
    logic                      xfer;
    logic [15:0]               len_rx;
    logic [ADDR_BUS_WIDTH-1:0] last_idx;
    logic                      tmo_clear;
    logic                      tmo_expired;

    assign active   = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                      (state_q == ST_DATA)   || (state_q == ST_CSUM);
    assign xfer     = bus.in_valid && active;
    assign len_rx   = {len_q[15:8], bus.in_data};
    assign last_idx = ADDR_BUS_WIDTH'(len_q - 16'd1);

    byte_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (tmo_clear),
        .en_i      (active && !xfer),
        .expired_o (tmo_expired)
    );

    // Frame sequencing, payload write generation and checksum accumulation.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        code_d    = code_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tmo_clear = xfer;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d   = ST_LEN_HI;
                    code_d    = ERR_NONE;
                    idx_d     = '0;
                    sum_d     = 8'd0;
                    tmo_clear = 1'b1;
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    len_d   = {bus.in_data, len_q[7:0]};
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    len_d = len_rx;
                    if (!len_legal(len_rx, MEM_BYTES)) begin
                        state_d = ST_ERR;
                        code_d  = ERR_LEN;
                    end else if (len_rx == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    we_d    = 1'b1;
                    addr_d  = idx_q;
                    wdata_d = bus.in_data;
                    sum_d   = sum_q + bus.in_data;
                    idx_d   = idx_q + ADDR_BUS_WIDTH'(1);
                    if (idx_q == last_idx) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    if (bus.in_data == sum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERR;
                        code_d  = ERR_CSUM;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Expiry only fires on a cycle with no accepted byte.
        if (tmo_expired) begin
            state_d = ST_ERR;
            code_d  = ERR_TIMEOUT;
        end
    end

    // State and datapath registers; reset aborts any frame immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= 16'd0;
            idx_q   <= '0;
            sum_q   <= 8'd0;
            code_q  <= ERR_NONE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            code_q  <= code_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.in_ready  = active;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign busy          = active;
    // Core stays stalled in ERR so a partial image never runs.
    assign cpu_hold      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done          = (state_q == ST_DONE);
    assign err           = (state_q == ST_ERR);
    assign err_code      = code_q;

endmodule
